mandel_coord_gen: RTL and testbench

Frame scanner that sits directly upstream of the Mandelbrot iterator. It walks every pixel of an H_RES × V_RES frame in raster order and emits the complex coordinate c = c_r + j·c_i for each pixel over a valid/ready handshake, in the iterator's signed Q4.23 input format. Each coordinate carries its pixel (x, y) tag so the downstream colour/framebuffer writer can address the result. Coordinates are computed incrementally from a latched origin and step, so the block contains no multipliers.

---
 rtl/mandel_coord_gen.sv | 91 +++++++++
 tb/tb_mandel_coord_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mandel_coord_gen.sv
// mandel_coord_gen: raster-order complex-coordinate generator feeding the Mandelbrot iterator
//   clk, reset (async, active-high)
//   start, x_start, y_start, step : frame request and origin/pitch (latched on accepted start)
//   out_val/out_rdy, out_c_r, out_c_i, out_x, out_y : per-pixel coordinate stream, signed Q4.23
//   busy (RUN or DONE), frame_done (one-cycle pulse after the last pixel)
//   MANDEL_COORD_GEN_LOOP_EN : when defined, frames repeat until reset
module mandel_coord_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int W     = 27
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [W-1:0]             x_start,
    input  logic [W-1:0]             y_start,
    input  logic [W-1:0]             step,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [W-1:0]             out_c_r,
    output logic [W-1:0]             out_c_i,
    output logic [$clog2(H_RES)-1:0] out_x,
    output logic [$clog2(V_RES)-1:0] out_y,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]   state;
    logic [W-1:0] xs, ys, st;
    logic         last_x, last_y;
    assign last_x     = out_x == XW'(H_RES - 1);
    assign last_y     = out_y == YW'(V_RES - 1);
    assign out_val    = state == RUN;
    assign busy       = state == RUN || state == DONE;
    assign frame_done = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            xs      <= '0;
            ys      <= '0;
            st      <= '0;
            out_c_r <= '0;
            out_c_i <= '0;
            out_x   <= '0;
            out_y   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    xs      <= x_start;
                    ys      <= y_start;
                    st      <= step;
                    out_c_r <= x_start;
                    out_c_i <= y_start;
                    out_x   <= '0;
                    out_y   <= '0;
                end
                RUN: if (out_rdy) begin
                    if (!last_x) begin
                        out_x   <= out_x + XW'(1);
                        out_c_r <= out_c_r + st;
                    end else if (!last_y) begin
                        // imaginary axis decreases going down the frame
                        out_x   <= '0;
                        out_y   <= out_y + YW'(1);
                        out_c_r <= xs;
                        out_c_i <= out_c_i - st;
                    end else begin
                        state <= DONE;
                    end
                end
`ifdef MANDEL_COORD_GEN_LOOP_EN
                DONE: begin
                    state   <= RUN;
                    out_c_r <= xs;
                    out_c_i <= ys;
                    out_x   <= '0;
                    out_y   <= '0;
                end
`else
                DONE: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mandel_coord_gen.sv
// tb_mandel_coord_gen: directed self-checking bench for mandel_coord_gen at 4x3
module tb_mandel_coord_gen;
    localparam int H = 4;
    localparam int V = 3;
    localparam int W = 27;
    logic         clk = 0, reset = 1, start = 0, out_rdy = 0;
    logic [W-1:0] x_start = 27'h7000000, y_start = 27'h0800000, step = 27'h0400000;
    logic         out_val, busy, frame_done;
    logic [W-1:0] out_c_r, out_c_i;
    logic [1:0]   out_x, out_y;
    int n_chk = 0, n_pass = 0;
    logic [W-1:0] row_cr[4] = '{27'h7000000, 27'h7400000, 27'h7800000, 27'h7C00000};
    logic [W-1:0] row_ci[3] = '{27'h0800000, 27'h0400000, 27'h0000000};

    mandel_coord_gen #(.H_RES(H), .V_RES(V), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .x_start(x_start), .y_start(y_start),
        .step(step), .out_val(out_val), .out_rdy(out_rdy), .out_c_r(out_c_r),
        .out_c_i(out_c_i), .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Walks n_pix transfers checking every offered pixel (including stalled cycles,
    // which proves stability); a full frame also checks the DONE cycle and after.
    task automatic run_frame(input bit stall, input bit poke, input int n_pix);
        int k = 0, cyc = 0;
        logic [15:0] lfsr = 16'hACE1;
        if (poke) begin
            x_start = 27'h0000000;
            y_start = 27'h1234567;
            step    = 27'h0100000;
        end
        while (k < n_pix && cyc < 200) begin
            chk("val", out_val, 1);
            chk("busy", busy, 1);
            chk("fd", frame_done, 0);
            chk("c_r", out_c_r, row_cr[k % 4]);
            chk("c_i", out_c_i, row_ci[k / 4]);
            chk("x", out_x, k % 4);
            chk("y", out_y, k / 4);
            out_rdy = stall ? lfsr[0] : 1'b1;
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            start = poke && k >= 5 && k < 7;
            @(negedge clk);
            if (out_rdy) k++;
            cyc++;
        end
        start = 0;
        chk("transfers", k, n_pix);
        if (n_pix == H * V) begin
            chk("done_val", out_val, 0);
            chk("done_fd", frame_done, 1);
            chk("done_busy", busy, 1);
            start = poke;
            @(negedge clk);
            start = 0;
`ifdef MANDEL_COORD_GEN_LOOP_EN
            chk("loop_val", out_val, 1);
            chk("loop_busy", busy, 1);
            chk("loop_fd", frame_done, 0);
            chk("loop_x", out_x, 0);
            chk("loop_y", out_y, 0);
            chk("loop_cr", out_c_r, 27'h7000000);
            chk("loop_ci", out_c_i, 27'h0800000);
`else
            chk("idle_val", out_val, 0);
            chk("idle_busy", busy, 0);
            chk("idle_fd", frame_done, 0);
`endif
        end
        x_start = 27'h7000000;
        y_start = 27'h0800000;
        step    = 27'h0400000;
    endtask

    task automatic reset_test;
        reset = 1;
        #1;
        chk("rst_val", out_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_cr", out_c_r, 0);
        chk("rst_x", out_x, 0);
        @(negedge clk);
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_fd", frame_done, 0);
            chk("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("init_val", out_val, 0);
        chk("init_cr", out_c_r, 0);
        chk("init_ci", out_c_i, 0);
        reset = 0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_val", out_val, 0);
            chk("idle_busy", busy, 0);
            chk("idle_fd", frame_done, 0);
            chk("idle_c", {out_c_r[15:0], out_c_i[15:0]}, 0);
            chk("idle_xy", {out_x, out_y}, 0);
        end
        do_start;
        run_frame(0, 0, H * V);
`ifdef MANDEL_COORD_GEN_LOOP_EN
        run_frame(1, 0, H * V);
        run_frame(0, 1, H * V);
        run_frame(0, 0, 5);
        reset_test();
        do_start;
        run_frame(0, 0, H * V);
`else
        do_start;
        run_frame(1, 0, H * V);
        do_start;
        run_frame(0, 1, H * V);
        do_start;
        run_frame(0, 0, 5);
        reset_test();
        do_start;
        run_frame(0, 0, H * V);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
